// File: rtl/time_sender_pkg.sv
// Shared constants and types for the time-to-ASCII frame sender.
package time_sender_pkg;

   localparam logic [7:0] ZERO = 8'h30;
   localparam logic [7:0] CR   = 8'h0D;
   localparam logic [7:0] LF   = 8'h0A;

   localparam int FRAME_LEN_BASE = 11;
   localparam int FRAME_LEN_CRLF = 13;

   localparam int IDX_W = 4;

   typedef enum logic {
      IDLE,
      SEND
   } state_e;

endpackage

// File: rtl/bcd_to_ascii.sv
// Combinational BCD nibble to ASCII digit; non-decimal nibbles map to BAD_CHAR.
module bcd_to_ascii
   import time_sender_pkg::*;
#(
   parameter logic [7:0] BAD_CHAR = 8'h3F
) (
   input  logic [3:0] i_nibble,
   output logic [7:0] o_ascii
);

   assign o_ascii = (i_nibble <= 4'd9) ? (ZERO + {4'h0, i_nibble}) : BAD_CHAR;

endmodule

// File: rtl/time_ascii_sender.sv
// Snapshots a packed BCD time word on request and streams it as "HH:MM:SS.CC"
// over a valid/ready byte interface. Define TIME_ASCII_SENDER_CRLF_EN to append CR LF.
module time_ascii_sender
   import time_sender_pkg::*;
#(
   parameter logic [7:0] SEP_HM   = 8'h3A,
   parameter logic [7:0] SEP_MS   = 8'h3A,
   parameter logic [7:0] SEP_SC   = 8'h2E,
   parameter logic [7:0] BAD_CHAR = 8'h3F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_trig,
   input  logic [31:0] i_bcd_time,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_busy,
   output logic        o_done
);

`ifdef TIME_ASCII_SENDER_CRLF_EN
   localparam int FRAME_LEN = FRAME_LEN_CRLF;
`else
   localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [31:0]       snap_q, snap_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_valid_q, tx_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [31:0]       load_word;
   logic [IDX_W-1:0]  load_idx;
   logic [3:0]        nibble;
   logic [7:0]        digit_ascii;
   logic [7:0]        next_byte;

   // The byte about to be registered: byte 0 of the live word on a trigger,
   // otherwise the byte after the current one from the snapshot.
   always_comb begin
      load_word = (state_q == IDLE) ? i_bcd_time : snap_q;
      load_idx  = (state_q == IDLE) ? '0 : idx_q + IDX_W'(1);

      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      nibble = 4'h0;
      case (load_idx)
         4'd0:    nibble = load_word[31:28];
         4'd1:    nibble = load_word[27:24];
         4'd3:    nibble = load_word[23:20];
         4'd4:    nibble = load_word[19:16];
         4'd6:    nibble = load_word[15:12];
         4'd7:    nibble = load_word[11:8];
         4'd9:    nibble = load_word[7:4];
         4'd10:   nibble = load_word[3:0];
         default: ;
      endcase
   end

   bcd_to_ascii #(
      .BAD_CHAR (BAD_CHAR)
   ) u_bcd_to_ascii (
      .i_nibble (nibble),
      .o_ascii  (digit_ascii)
   );

   always_comb begin
      next_byte = digit_ascii;
      case (load_idx)
         4'd2:    next_byte = SEP_HM;
         4'd5:    next_byte = SEP_MS;
         4'd8:    next_byte = SEP_SC;
`ifdef TIME_ASCII_SENDER_CRLF_EN
         4'd11:   next_byte = CR;
         4'd12:   next_byte = LF;
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      snap_d     = snap_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_trig) begin
               snap_d     = i_bcd_time;
               idx_d      = '0;
               tx_data_d  = next_byte;
               tx_valid_d = 1'b1;
               busy_d     = 1'b1;
               state_d    = SEND;
            end
         end
         SEND: begin
            // Triggers are not looked at here, so they are dropped rather than queued.
            if (tx_valid_q && i_tx_ready) begin
               if (idx_q == LAST_IDX) begin
                  tx_valid_d = 1'b0;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
                  state_d    = IDLE;
               end else begin
                  idx_d     = idx_q + IDX_W'(1);
                  tx_data_d = next_byte;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         snap_q     <= '0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         snap_q     <= snap_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign o_tx_data  = tx_data_q;
   assign o_tx_valid = tx_valid_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;

endmodule
